// File: rtl/uart_rx_core_pkg.sv
// Shared definitions for the UART receive path: state encodings, oversample
// indices and the majority-vote helper.
package uart_rx_core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] SMP_FIRST  = 4'd7;
  localparam logic [3:0] SMP_MID    = 4'd8;
  localparam logic [3:0] SMP_LAST   = 4'd9;
  localparam logic [3:0] SMP_END    = 4'd15;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every BAUD_DIV clocks, held
// at phase zero while i_clear is asserted.
module uart_baud_tick #(
  parameter int BAUD_DIV = 54
) (
  input  logic clk_uart,
  input  logic reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int               DIV_W    = $clog2(BAUD_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0] r_div;

  // Divider counter: wraps at BAUD_DIV-1, cleared synchronously
  always_ff @(posedge clk_uart or posedge reset) begin
    if (reset) begin
      r_div <= DIV_ZERO;
    end else if (i_clear || (r_div == DIV_LAST)) begin
      r_div <= DIV_ZERO;
    end else begin
      r_div <= r_div + DIV_ONE;
    end
  end

  assign o_tick = (r_div == DIV_LAST) && !i_clear;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver, LSB first, 16x oversampled with a 3-sample majority
// vote on ticks 7/8/9 of every bit.
module uart_rx_core
  import uart_rx_core_pkg::*;
#(
  parameter int BAUD_DIV = 54
) (
  input  logic       clk_uart,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_ready,
  output logic       frame_err
);

  rx_state_e   r_state;
  rx_state_e   w_state_nxt;
  logic [1:0]  r_sync;
  logic [3:0]  r_sample;
  logic [2:0]  r_bit_idx;
  logic [1:0]  r_votes;
  logic [7:0]  r_shift;
  logic        w_rx_s;
  logic        w_tick;
  logic        w_vote;
  logic        w_decide;
  logic        w_bit_end;
  logic        w_shift_en;
  logic        w_load;
  logic        w_ferr;
  logic        w_clr_ready;

  assign w_rx_s    = r_sync[1];
  assign w_vote    = maj3(r_votes[0], r_votes[1], w_rx_s);
  assign w_decide  = w_tick && (r_sample == SMP_LAST);
  assign w_bit_end = w_tick && (r_sample == SMP_END);

  uart_baud_tick #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_tick (
    .clk_uart (clk_uart),
    .reset    (reset),
    .i_clear  (r_state == ST_IDLE),
    .o_tick   (w_tick)
  );

  // Two-flop synchroniser for the asynchronous serial line
  always_ff @(posedge clk_uart or posedge reset) begin
    if (reset) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx};
    end
  end

  // State register
  always_ff @(posedge clk_uart or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_rx_s) w_state_nxt = ST_START;
        else         w_state_nxt = ST_IDLE;
      end
      ST_START: begin
        if (w_decide && w_vote) w_state_nxt = ST_IDLE;
        else if (w_bit_end)     w_state_nxt = ST_DATA;
        else                    w_state_nxt = ST_START;
      end
      ST_DATA: begin
        if (w_bit_end && (r_bit_idx == 3'd7)) w_state_nxt = ST_STOP;
        else                                  w_state_nxt = ST_DATA;
      end
      ST_STOP: begin
        if (w_decide) w_state_nxt = w_vote ? ST_IDLE : ST_BREAK;
        else          w_state_nxt = ST_STOP;
      end
      ST_BREAK: begin
        if (w_rx_s) w_state_nxt = ST_IDLE;
        else        w_state_nxt = ST_BREAK;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output strobes derived from state and the tick-9 decision
  always_comb begin
    w_shift_en  = 1'b0;
    w_load      = 1'b0;
    w_ferr      = 1'b0;
    w_clr_ready = 1'b0;
    case (r_state)
      ST_START: w_clr_ready = w_decide && !w_vote;
      ST_DATA:  w_shift_en  = w_decide;
      ST_STOP: begin
        w_load = w_decide && w_vote;
        w_ferr = w_decide && !w_vote;
      end
      default: w_shift_en = 1'b0;
    endcase
  end

  // Oversample counter, forced to zero while idle so each frame aligns to its start edge
  always_ff @(posedge clk_uart or posedge reset) begin
    if (reset) begin
      r_sample <= 4'd0;
    end else if (r_state == ST_IDLE) begin
      r_sample <= 4'd0;
    end else if (w_tick) begin
      r_sample <= r_sample + 4'd1;
    end else begin
      r_sample <= r_sample;
    end
  end

  // Early vote samples; the third comes live from the synchroniser on tick 9
  always_ff @(posedge clk_uart or posedge reset) begin
    if (reset) begin
      r_votes <= 2'b00;
    end else begin
      if (w_tick && (r_sample == SMP_FIRST)) r_votes[0] <= w_rx_s;
      if (w_tick && (r_sample == SMP_MID))   r_votes[1] <= w_rx_s;
    end
  end

  // Data bit index, held at zero outside the data phase
  always_ff @(posedge clk_uart or posedge reset) begin
    if (reset) begin
      r_bit_idx <= 3'd0;
    end else if (r_state != ST_DATA) begin
      r_bit_idx <= 3'd0;
    end else if (w_bit_end && (r_bit_idx != 3'd7)) begin
      r_bit_idx <= r_bit_idx + 3'd1;
    end else begin
      r_bit_idx <= r_bit_idx;
    end
  end

  // Shift register and registered outputs
  always_ff @(posedge clk_uart or posedge reset) begin
    if (reset) begin
      r_shift    <= 8'h00;
      data_out   <= 8'h00;
      data_ready <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (w_shift_en) r_shift <= {w_vote, r_shift[7:1]};
      if (w_load) begin
        data_out   <= r_shift;
        data_ready <= 1'b1;
        frame_err  <= 1'b0;
      end else if (w_ferr) begin
        frame_err  <= 1'b1;
      end else if (w_clr_ready) begin
        data_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at BAUD_DIV=4 (64 clocks per bit).
module tb_uart_rx_core;

  logic       clk_uart = 1'b0;
  logic       reset    = 1'b1;
  logic       rx       = 1'b1;
  logic [7:0] data_out;
  logic       data_ready;
  logic       frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int rise_lat = -1;
  int fall_lat = -1;
  logic dr_prev = 1'b0;

  uart_rx_core #(.BAUD_DIV(4)) dut (
    .clk_uart   (clk_uart),
    .reset      (reset),
    .rx         (rx),
    .data_out   (data_out),
    .data_ready (data_ready),
    .frame_err  (frame_err)
  );

  always #5 clk_uart = ~clk_uart;

  always @(posedge clk_uart) cyc <= cyc + 1;

  // Edge timestamps of data_ready relative to the latest start bit
  always @(negedge clk_uart) begin
    if (data_ready && !dr_prev) rise_lat = cyc - start_cyc;
    if (!data_ready && dr_prev) fall_lat = cyc - start_cyc;
    dr_prev = data_ready;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive nbits frame bits (start, data LSB first, stop), each per clocks long;
  // bit gbit is inverted for clocks 34..37, which only tick 8 sees.
  task automatic send_frame(input logic [7:0] d, input logic stopv, input int per,
                            input int gbit, input int nbits);
    logic [9:0] fr;
    fr = {stopv, d, 1'b0};
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < per; c++) begin
        @(negedge clk_uart);
        if (b == 0 && c == 0) start_cyc = cyc;
        rx = fr[b] ^ ((b == gbit) && (c >= 34) && (c < 38));
      end
    end
  endtask

  task automatic line_level(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_uart);
      rx = v;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk_uart);
    check_val("rst_data", data_out, 8'h00);
    check_val("rst_ready", data_ready, 1'b0);
    check_val("rst_ferr", frame_err, 1'b0);
    reset = 1'b0;
    line_level(1'b1, 10);

    // 1: nominal 0x55 with latency window
    rise_lat = -1;
    send_frame(8'h55, 1'b1, 64, -1, 10);
    line_level(1'b1, 20);
    check_val("t1_data", data_out, 8'h55);
    check_val("t1_ready", data_ready, 1'b1);
    check_val("t1_ferr", frame_err, 1'b0);
    check_val("t1_lat_in_616_620", (rise_lat >= 616 && rise_lat <= 620) ? 32'd1 : 32'd0, 32'd1);

    // 2: back-to-back 0xA5, 0x3C
    send_frame(8'hA5, 1'b1, 64, -1, 10);
    check_val("t2_first_data", data_out, 8'hA5);
    check_val("t2_first_ready", data_ready, 1'b1);
    fall_lat = -1;
    rise_lat = -1;
    send_frame(8'h3C, 1'b1, 64, -1, 10);
    line_level(1'b1, 20);
    check_val("t2_fall_lat_40_44", (fall_lat >= 40 && fall_lat <= 44) ? 32'd1 : 32'd0, 32'd1);
    check_val("t2_second_data", data_out, 8'h3C);
    check_val("t2_second_ready", data_ready, 1'b1);
    check_val("t2_rise_lat_616_620", (rise_lat >= 616 && rise_lat <= 620) ? 32'd1 : 32'd0, 32'd1);

    // 3: 8-clock glitch on idle line
    line_level(1'b0, 8);
    line_level(1'b1, 200);
    check_val("t3_ready", data_ready, 1'b1);
    check_val("t3_data", data_out, 8'h3C);

    // 4: 0x81 with stop=0 then line held low three bit times
    send_frame(8'h81, 1'b0, 64, -1, 10);
    line_level(1'b0, 192);
    check_val("t4_ferr", frame_err, 1'b1);
    check_val("t4_ready", data_ready, 1'b0);
    check_val("t4_data_kept", data_out, 8'h3C);
    line_level(1'b1, 64);
    check_val("t4_ready_after_high", data_ready, 1'b0);
    send_frame(8'h42, 1'b1, 64, -1, 10);
    line_level(1'b1, 20);
    check_val("t4_recover_data", data_out, 8'h42);
    check_val("t4_recover_ferr", frame_err, 1'b0);
    check_val("t4_recover_ready", data_ready, 1'b1);

    // 5: single-tick glitch on data bit 3, then +-3% bit periods
    send_frame(8'hF0, 1'b1, 64, 4, 10);
    line_level(1'b1, 20);
    check_val("t5_glitch_data", data_out, 8'hF0);
    send_frame(8'h00, 1'b1, 64, -1, 10);
    line_level(1'b1, 20);
    check_val("t5_sep_data", data_out, 8'h00);
    send_frame(8'hF0, 1'b1, 62, -1, 10);
    line_level(1'b1, 20);
    check_val("t5_fast_data", data_out, 8'hF0);
    check_val("t5_fast_ready", data_ready, 1'b1);
    send_frame(8'h00, 1'b1, 64, -1, 10);
    line_level(1'b1, 20);
    send_frame(8'hF0, 1'b1, 66, -1, 10);
    line_level(1'b1, 20);
    check_val("t5_slow_data", data_out, 8'hF0);
    check_val("t5_slow_ferr", frame_err, 1'b0);

    // 6: reset in the middle of data bit 4 of 0x99
    send_frame(8'h99, 1'b1, 64, -1, 5);
    line_level(1'b1, 20);
    reset = 1'b1;
    #1;
    check_val("t6_rst_data", data_out, 8'h00);
    check_val("t6_rst_ready", data_ready, 1'b0);
    check_val("t6_rst_ferr", frame_err, 1'b0);
    line_level(1'b1, 4);
    reset = 1'b0;
    line_level(1'b1, 20);
    send_frame(8'h27, 1'b1, 64, -1, 10);
    line_level(1'b1, 20);
    check_val("t6_after_data", data_out, 8'h27);
    check_val("t6_after_ready", data_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
